// File: rtl/fifo_pkg.sv
// Shared widths and state encoding for the sample-FIFO consumer blocks.
package fifo_pkg;

    localparam int DW = 16;
    localparam int AW = 7;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_FILL = 2'd1,
        STREAM    = 2'd2,
        DONE      = 2'd3
    } state_t;

endpackage

// File: rtl/frame_out_reg.sv
// Output holding register for a valid/ready stream fed from a show-ahead FIFO.
// A held word stays put until it is accepted; a load may replace it in the accept cycle.
module frame_out_reg #(
    parameter int DW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          load_i,
    input  logic          ready_i,
    input  logic [DW-1:0] data_i,
    input  logic          last_i,
    output logic [DW-1:0] data_o,
    output logic          valid_o,
    output logic          last_o
);

    logic [DW-1:0] data_q;
    logic          valid_q;
    logic          last_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            valid_q <= 1'b1;
            last_q  <= last_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;

endmodule

// File: rtl/fifo_frame_reader.sv
// Consumer end of the show-ahead sample FIFO: waits for a full frame, then streams it out.
//   state     | meaning
//   IDLE      | waiting for start
//   WAIT_FILL | waiting for FRAME_LEN words in the FIFO, bounded by TIMEOUT
//   STREAM    | popping words into the output register until the last is accepted
//   DONE      | one-cycle frame completion
module fifo_frame_reader
    import fifo_pkg::*;
#(
    parameter int DW        = fifo_pkg::DW,
    parameter int AW        = fifo_pkg::AW,
    parameter int FRAME_LEN = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clock,
    input  logic                 sclr,
    input  logic                 start,
    input  logic                 flush,
    input  logic signed [DW-1:0] fifo_q,
    input  logic                 fifo_empty,
    input  logic        [AW-1:0] fifo_usedw,
    output logic                 fifo_rdreq,
    output logic                 fifo_sclr,
    output logic signed [DW-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 underrun,
    output logic        [15:0]   frame_cnt
);

    localparam int WCW = $clog2(TIMEOUT + 1);

    state_t         state_q, state_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic [AW-1:0]  rem_q, rem_d;
    logic [15:0]    frame_cnt_q, frame_cnt_d;
    logic           underrun_q, underrun_d;
    logic           fifo_sclr_q;
    logic           load;
    logic           accept;
    logic [DW-1:0]  out_data_raw;

    assign accept = out_valid & out_ready;
    // Flush must not pop: the word would be lost to the clear anyway.
    assign load   = (state_q == STREAM) && (rem_q != '0) && !fifo_empty &&
                    (!out_valid || out_ready) && !flush;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        rem_d       = rem_q;
        frame_cnt_d = frame_cnt_q;
        underrun_d  = 1'b0;
        if (flush) begin
            state_d    = IDLE;
            wait_cnt_d = '0;
            rem_d      = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d    = WAIT_FILL;
                        wait_cnt_d = '0;
                        rem_d      = AW'(FRAME_LEN);
                    end
                end
                WAIT_FILL: begin
                    if (fifo_usedw >= AW'(FRAME_LEN)) begin
                        state_d = STREAM;
                    end else if (wait_cnt_q == WCW'(TIMEOUT)) begin
                        underrun_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
                STREAM: begin
                    if (load) rem_d = rem_q - 1'b1;
                    if (accept && out_last) state_d = DONE;
                end
                DONE: begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (sclr) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            rem_q       <= '0;
            frame_cnt_q <= '0;
            underrun_q  <= 1'b0;
            fifo_sclr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            rem_q       <= rem_d;
            frame_cnt_q <= frame_cnt_d;
            underrun_q  <= underrun_d;
            fifo_sclr_q <= flush;
        end
    end

    frame_out_reg #(.DW(DW)) u_out (
        .clk_i   (clock),
        .rst_i   (sclr),
        .clear_i (flush),
        .load_i  (load),
        .ready_i (out_ready),
        .data_i  (fifo_q),
        .last_i  (rem_q == AW'(1)),
        .data_o  (out_data_raw),
        .valid_o (out_valid),
        .last_o  (out_last)
    );

    assign out_data   = out_data_raw;
    assign fifo_rdreq = load;
    assign fifo_sclr  = fifo_sclr_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE) && !flush;
    assign underrun   = underrun_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Directed bench for fifo_frame_reader with a show-ahead FIFO model and a stream monitor.
module tb_fifo_frame_reader;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        sclr, start, flush, out_ready, start1;
    logic [15:0] fifo_q;
    logic        fifo_empty;
    logic [6:0]  fifo_usedw;
    logic        fifo_rdreq, fifo_sclr, out_valid, out_last, busy, frame_done, underrun;
    logic [15:0] out_data, frame_cnt;

    logic        one_rdreq, one_sclr, one_valid, one_last, one_busy, one_done, one_underrun;
    logic [15:0] one_data, one_cnt;

    int n_cmp = 0;
    int n_err = 0;

    fifo_frame_reader #(.DW(16), .AW(7), .FRAME_LEN(32), .TIMEOUT(255)) dut (
        .clock(clock), .sclr(sclr), .start(start), .flush(flush),
        .fifo_q(fifo_q), .fifo_empty(fifo_empty), .fifo_usedw(fifo_usedw),
        .fifo_rdreq(fifo_rdreq), .fifo_sclr(fifo_sclr),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .frame_done(frame_done), .underrun(underrun), .frame_cnt(frame_cnt)
    );

    // Single-word frames against a source that always has a word ready.
    fifo_frame_reader #(.DW(16), .AW(7), .FRAME_LEN(1), .TIMEOUT(255)) u_one (
        .clock(clock), .sclr(sclr), .start(start1), .flush(flush),
        .fifo_q(16'h5A5A), .fifo_empty(1'b0), .fifo_usedw(7'd1),
        .fifo_rdreq(one_rdreq), .fifo_sclr(one_sclr),
        .out_data(one_data), .out_valid(one_valid), .out_ready(out_ready), .out_last(one_last),
        .busy(one_busy), .frame_done(one_done), .underrun(one_underrun), .frame_cnt(one_cnt)
    );

    // Show-ahead FIFO model; usedw can be overridden to fake in-flight words.
    logic [15:0] mem [0:127];
    logic [7:0]  wp = 8'd0;
    logic [7:0]  rp = 8'd0;
    logic [7:0]  fcount;
    logic        wr_en, tb_clr, force_en;
    logic [15:0] wr_data;
    logic [6:0]  force_usedw;

    assign fcount     = wp - rp;
    assign fifo_empty = (fcount == 8'd0);
    assign fifo_q     = mem[rp[6:0]];
    assign fifo_usedw = force_en ? force_usedw : fcount[6:0];

    always @(posedge clock) begin
        if (fifo_sclr || tb_clr) begin
            wp <= 8'd0;
            rp <= 8'd0;
        end else begin
            if (wr_en) begin
                mem[wp[6:0]] <= wr_data;
                wp <= wp + 8'd1;
            end
            if (fifo_rdreq && !fifo_empty) rp <= rp + 8'd1;
        end
    end

    // Stream monitor, sampled mid-cycle.
    logic [16:0] acc [$];
    int          rd_n = 0, rd_empty_n = 0, done_n = 0, under_n = 0, hold_viol = 0;
    logic        stall_prev = 1'b0;
    logic [16:0] stall_word = 17'd0;

    always @(negedge clock) begin
        if (out_valid && out_ready) acc.push_back({out_last, out_data});
        if (fifo_rdreq) rd_n++;
        if (fifo_rdreq && fifo_empty) rd_empty_n++;
        if (frame_done) done_n++;
        if (underrun) under_n++;
        if (stall_prev && !(out_valid && ({out_last, out_data} == stall_word))) hold_viol++;
        stall_prev = out_valid && !out_ready && !flush && !sclr;
        stall_word = {out_last, out_data};
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic fill(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = base + 16'(i);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        sclr = 1'b1; start = 1'b1; flush = 1'b1; start1 = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({out_valid, out_last, busy, frame_done, underrun, fifo_sclr, fifo_rdreq} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {out_valid, out_last, busy, frame_done, underrun, fifo_sclr, fifo_rdreq});
        end
        n_cmp++;
        if (out_data !== 16'h0000 || frame_cnt !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_data: got data=%h cnt=%h want 0000/0000", out_data, frame_cnt);
        end
        n_cmp++;
        if (one_busy !== 1'b0 || one_cnt !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_one: got busy=%b cnt=%h want 0/0000", one_busy, one_cnt);
        end
        sclr = 1'b0; start = 1'b0; flush = 1'b0; start1 = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || fifo_sclr !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got busy=%b fifo_sclr=%b want 0/0", busy, fifo_sclr);
        end
    endtask

    task automatic test_frame_len_one();
        out_ready = 1'b1;
        start1 = 1'b1; tick(); start1 = 1'b0;
        n_cmp++;
        if (one_busy !== 1'b1 || one_rdreq !== 1'b0) begin
            n_err++;
            $display("FAIL len1_wait: got busy=%b rdreq=%b want 1/0", one_busy, one_rdreq);
        end
        tick();
        n_cmp++;
        if (one_rdreq !== 1'b1) begin
            n_err++;
            $display("FAIL len1_rdreq: got %b want 1", one_rdreq);
        end
        tick();
        n_cmp++;
        if ({one_valid, one_last, one_data, one_rdreq} !== {1'b1, 1'b1, 16'h5A5A, 1'b0}) begin
            n_err++;
            $display("FAIL len1_word: got v=%b l=%b d=%h rd=%b want 1/1/5a5a/0",
                     one_valid, one_last, one_data, one_rdreq);
        end
        tick();
        n_cmp++;
        if (one_done !== 1'b1) begin
            n_err++;
            $display("FAIL len1_done: got %b want 1", one_done);
        end
        tick();
        n_cmp++;
        if (one_done !== 1'b0 || one_cnt !== 16'd1 || one_busy !== 1'b0) begin
            n_err++;
            $display("FAIL len1_end: got done=%b cnt=%0d busy=%b want 0/1/0", one_done, one_cnt, one_busy);
        end
    endtask

    task automatic test_frame();
        int          a0, r0, d0, k;
        logic [15:0] fc0;
        logic [16:0] exp;
        fill(32, 16'd0);
        a0 = acc.size(); r0 = rd_n; d0 = done_n; fc0 = frame_cnt;
        out_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || fifo_rdreq !== 1'b0) begin
            n_err++;
            $display("FAIL t1_wait_fill: got busy=%b rdreq=%b want 1/0", busy, fifo_rdreq);
        end
        tick();
        n_cmp++;
        if (fifo_rdreq !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL t1_first_rdreq: got rdreq=%b valid=%b want 1/0", fifo_rdreq, out_valid);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 16'd0) begin
            n_err++;
            $display("FAIL t1_first_valid: got valid=%b data=%h want 1/0000", out_valid, out_data);
        end
        k = 0;
        while (frame_done !== 1'b1 && k < 100) begin tick(); k++; end
        n_cmp++;
        if (k != 32) begin
            n_err++;
            $display("FAIL t1_done_latency: got %0d cycles want 32", k);
        end
        tick();
        n_cmp++;
        if (frame_done !== 1'b0 || frame_cnt !== fc0 + 16'd1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL t1_end: got done=%b cnt=%0d busy=%b want 0/%0d/0", frame_done, frame_cnt, busy, fc0 + 16'd1);
        end
        n_cmp++;
        if (acc.size() - a0 != 32 || rd_n - r0 != 32 || done_n - d0 != 1) begin
            n_err++;
            $display("FAIL t1_counts: got acc=%0d rd=%0d done=%0d want 32/32/1", acc.size() - a0, rd_n - r0, done_n - d0);
        end
        for (int i = 0; i < 32 && a0 + i < acc.size(); i++) begin
            exp = {(i == 31), 16'(i)};
            n_cmp++;
            if (acc[a0 + i] !== exp) begin
                n_err++;
                $display("FAIL t1_word%0d: got %h want %h", i, acc[a0 + i], exp);
            end
        end
    endtask

    task automatic test_backpressure();
        int          a0, h0, k;
        logic [15:0] fc0;
        logic [16:0] exp;
        fill(32, 16'h8000);
        a0 = acc.size(); h0 = hold_viol; fc0 = frame_cnt;
        out_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        k = 0;
        while (frame_done !== 1'b1 && k < 300) begin
            tick(); k++;
            out_ready = ~out_ready;
        end
        out_ready = 1'b1;
        tick();
        n_cmp++;
        if (k >= 300 || frame_cnt !== fc0 + 16'd1) begin
            n_err++;
            $display("FAIL t2_done: got cycles=%0d cnt=%0d want <300/%0d", k, frame_cnt, fc0 + 16'd1);
        end
        n_cmp++;
        if (hold_viol - h0 != 0) begin
            n_err++;
            $display("FAIL t2_hold: got %0d violations want 0", hold_viol - h0);
        end
        n_cmp++;
        if (acc.size() - a0 != 32 || fcount != 8'd0) begin
            n_err++;
            $display("FAIL t2_counts: got acc=%0d fifo=%0d want 32/0", acc.size() - a0, fcount);
        end
        for (int i = 0; i < 32 && a0 + i < acc.size(); i++) begin
            exp = {(i == 31), 16'h8000 + 16'(i)};
            n_cmp++;
            if (acc[a0 + i] !== exp) begin
                n_err++;
                $display("FAIL t2_word%0d: got %h want %h", i, acc[a0 + i], exp);
            end
        end
    endtask

    task automatic test_underrun();
        int          r0, u0, k;
        logic [15:0] fc0;
        fill(10, 16'h0100);
        r0 = rd_n; u0 = under_n; fc0 = frame_cnt;
        start = 1'b1; tick(); start = 1'b0;
        k = 0;
        while (underrun !== 1'b1 && k < 400) begin tick(); k++; end
        n_cmp++;
        if (k != 256 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL t3_timeout: got cycles=%0d busy=%b want 256/0", k, busy);
        end
        tick();
        n_cmp++;
        if (underrun !== 1'b0 || under_n - u0 != 1) begin
            n_err++;
            $display("FAIL t3_pulse: got underrun=%b pulses=%0d want 0/1", underrun, under_n - u0);
        end
        n_cmp++;
        if (rd_n - r0 != 0 || frame_cnt !== fc0 || fcount != 8'd10) begin
            n_err++;
            $display("FAIL t3_side: got rd=%0d cnt=%0d fifo=%0d want 0/%0d/10", rd_n - r0, frame_cnt, fcount, fc0);
        end
        flush = 1'b1; tick(); flush = 1'b0;
        n_cmp++;
        if (fifo_sclr !== 1'b1) begin
            n_err++;
            $display("FAIL t3_sclr_on: got %b want 1", fifo_sclr);
        end
        tick();
        n_cmp++;
        if (fifo_sclr !== 1'b0 || fcount != 8'd0) begin
            n_err++;
            $display("FAIL t3_sclr_off: got sclr=%b fifo=%0d want 0/0", fifo_sclr, fcount);
        end
    endtask

    task automatic test_flush();
        int          a0, d0, n, k;
        logic [15:0] fc0;
        logic [16:0] exp;
        fill(32, 16'd0);
        a0 = acc.size(); d0 = done_n; fc0 = frame_cnt;
        out_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        n = 0; k = 0;
        while (n < 12 && k < 100) begin
            tick(); k++;
            if (out_valid && out_ready) n++;
        end
        flush = 1'b1;
        #1;
        n_cmp++;
        if (fifo_rdreq !== 1'b0) begin
            n_err++;
            $display("FAIL t4_rdreq_in_flush: got %b want 0", fifo_rdreq);
        end
        tick(); flush = 1'b0;
        n_cmp++;
        if ({fifo_sclr, out_valid, out_last, busy} !== 4'b1000) begin
            n_err++;
            $display("FAIL t4_after_flush: got sclr/v/l/busy=%b want 1000", {fifo_sclr, out_valid, out_last, busy});
        end
        tick();
        n_cmp++;
        if (fifo_sclr !== 1'b0 || fcount != 8'd0 || done_n != d0 || frame_cnt !== fc0) begin
            n_err++;
            $display("FAIL t4_abort: got sclr=%b fifo=%0d done=%0d cnt=%0d want 0/0/0/%0d",
                     fifo_sclr, fcount, done_n - d0, frame_cnt, fc0);
        end
        n_cmp++;
        if (acc.size() - a0 != 12) begin
            n_err++;
            $display("FAIL t4_partial: got %0d words want 12", acc.size() - a0);
        end
        for (int i = 0; i < 12 && a0 + i < acc.size(); i++) begin
            exp = {1'b0, 16'(i)};
            n_cmp++;
            if (acc[a0 + i] !== exp) begin
                n_err++;
                $display("FAIL t4_word%0d: got %h want %h", i, acc[a0 + i], exp);
            end
        end
        fill(32, 16'd100);
        a0 = acc.size();
        start = 1'b1; tick(); start = 1'b0;
        k = 0;
        while (frame_done !== 1'b1 && k < 100) begin tick(); k++; end
        tick();
        n_cmp++;
        if (frame_cnt !== fc0 + 16'd1 || acc.size() - a0 != 32) begin
            n_err++;
            $display("FAIL t4_refill: got cnt=%0d words=%0d want %0d/32", frame_cnt, acc.size() - a0, fc0 + 16'd1);
        end
        for (int i = 0; i < 32 && a0 + i < acc.size(); i++) begin
            exp = {(i == 31), 16'd100 + 16'(i)};
            n_cmp++;
            if (acc[a0 + i] !== exp) begin
                n_err++;
                $display("FAIL t4_refill_word%0d: got %h want %h", i, acc[a0 + i], exp);
            end
        end
    endtask

    task automatic test_trickle();
        int          a0, e0, k, written;
        logic [15:0] fc0;
        logic [16:0] exp;
        fill(2, 16'h0200);
        force_en = 1'b1; force_usedw = 7'd32;
        a0 = acc.size(); e0 = rd_empty_n; fc0 = frame_cnt;
        out_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        force_en = 1'b0;
        written = 2; k = 0;
        while (frame_done !== 1'b1 && k < 400) begin
            wr_en   = (k % 3 == 0) && (written < 32);
            wr_data = 16'h0200 + 16'(written);
            if (wr_en) written++;
            tick(); k++;
        end
        wr_en = 1'b0;
        tick();
        n_cmp++;
        if (k < 88 || k >= 120 || frame_cnt !== fc0 + 16'd1) begin
            n_err++;
            $display("FAIL t5_done: got cycles=%0d cnt=%0d want 88..119/%0d", k, frame_cnt, fc0 + 16'd1);
        end
        n_cmp++;
        if (rd_empty_n - e0 != 0) begin
            n_err++;
            $display("FAIL t5_rdreq_empty: got %0d pops while empty want 0", rd_empty_n - e0);
        end
        n_cmp++;
        if (acc.size() - a0 != 32) begin
            n_err++;
            $display("FAIL t5_count: got %0d words want 32", acc.size() - a0);
        end
        for (int i = 0; i < 32 && a0 + i < acc.size(); i++) begin
            exp = {(i == 31), 16'h0200 + 16'(i)};
            n_cmp++;
            if (acc[a0 + i] !== exp) begin
                n_err++;
                $display("FAIL t5_word%0d: got %h want %h", i, acc[a0 + i], exp);
            end
        end
    endtask

    task automatic test_sclr_and_races();
        int a0, d0, k;
        fill(32, 16'd0);
        out_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        repeat (8) tick();
        n_cmp++;
        if (busy !== 1'b1 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL t6_streaming: got busy=%b valid=%b want 1/1", busy, out_valid);
        end
        sclr = 1'b1; tick();
        n_cmp++;
        if ({out_valid, out_last, busy, frame_done, underrun, fifo_sclr} !== 6'b0 ||
            out_data !== 16'h0000 || frame_cnt !== 16'h0000) begin
            n_err++;
            $display("FAIL t6_sclr: got flags=%b data=%h cnt=%h want 000000/0000/0000",
                     {out_valid, out_last, busy, frame_done, underrun, fifo_sclr}, out_data, frame_cnt);
        end
        sclr = 1'b0; tb_clr = 1'b1; tick(); tb_clr = 1'b0;
        start = 1'b1; flush = 1'b1; tick(); start = 1'b0; flush = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || fifo_sclr !== 1'b1) begin
            n_err++;
            $display("FAIL t6_start_flush: got busy=%b sclr=%b want 0/1", busy, fifo_sclr);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL t6_start_dropped: got busy=%b want 0", busy);
        end
        fill(64, 16'h0300);
        a0 = acc.size(); d0 = done_n;
        start = 1'b1; tick(); start = 1'b0;
        repeat (5) tick();
        start = 1'b1; tick(); start = 1'b0;
        k = 0;
        while (frame_done !== 1'b1 && k < 100) begin tick(); k++; end
        repeat (10) tick();
        n_cmp++;
        if (busy !== 1'b0 || done_n - d0 != 1 || frame_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL t6_no_queue: got busy=%b done=%0d cnt=%0d want 0/1/1", busy, done_n - d0, frame_cnt);
        end
        n_cmp++;
        if (fcount != 8'd32 || acc.size() - a0 != 32) begin
            n_err++;
            $display("FAIL t6_words: got fifo=%0d words=%0d want 32/32", fcount, acc.size() - a0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sclr = 1'b1; start = 1'b0; flush = 1'b0; start1 = 1'b0; out_ready = 1'b0;
        wr_en = 1'b0; wr_data = 16'd0; tb_clr = 1'b0; force_en = 1'b0; force_usedw = 7'd0;
        test_reset();
        test_frame_len_one();
        test_frame();
        test_backpressure();
        test_underrun();
        test_flush();
        test_trickle();
        test_sclr_and_races();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
